// File: rtl/ocp_ram_slave_pkg.sv
// Shared OCP constants, bus widths and FSM state encodings for the RAM slave.
// Pure declarations, no timing.
// No flow control of its own.
package ocp_ram_slave_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int BEN_WIDTH  = DATA_WIDTH / 8;

  // OCP command codes; 3..7 are unsupported and answered with FAIL
  localparam logic [2:0] CMD_IDLE = 3'd0;
  localparam logic [2:0] CMD_WR   = 3'd1;
  localparam logic [2:0] CMD_RD   = 3'd2;

  // OCP response codes
  localparam logic [1:0] RESP_NULL = 2'd0;
  localparam logic [1:0] RESP_DVA  = 2'd1;
  localparam logic [1:0] RESP_FAIL = 2'd2;
  localparam logic [1:0] RESP_ERR  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Response code for an accepted command; an unsupported command wins over a bad address
  function automatic logic [1:0] access_resp(input logic [2:0] cmd, input logic bad_addr);
    if (cmd != CMD_WR && cmd != CMD_RD) return RESP_FAIL;
    if (bad_addr) return RESP_ERR;
    return RESP_DVA;
  endfunction

endpackage

// File: rtl/ocp_ram_slave_if.sv
// OCP request/response bundle between the bus converter (master) and the RAM slave.
// Wires only, no latency.
// Master holds the command stable until scmd_accept is seen.
interface ocp_ram_slave_if;
  import ocp_ram_slave_pkg::*;

  logic [ADDR_WIDTH-1:0] maddr;
  logic [2:0]            mcmd;
  logic [DATA_WIDTH-1:0] mdata;
  logic [BEN_WIDTH-1:0]  mbyte_en;
  logic                  scmd_accept;
  logic [DATA_WIDTH-1:0] sdata;
  logic [1:0]            sresp;

  modport master (
    output maddr, mcmd, mdata, mbyte_en,
    input  scmd_accept, sdata, sresp
  );

  modport slave (
    input  maddr, mcmd, mdata, mbyte_en,
    output scmd_accept, sdata, sresp
  );

endinterface

// File: rtl/ocp_ram_array.sv
// Synchronous single-port RAM, 2^ADDR_BITS x 32, per-byte write enables.
// Read data registered: valid the cycle after re.
// No backpressure; one access per cycle, contents are never reset.
module ocp_ram_array
  import ocp_ram_slave_pkg::*;
#(
  parameter int ADDR_BITS = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_BITS-1:0]  addr,
  input  logic [BEN_WIDTH-1:0]  ben,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];

  // Byte-lane write: only lanes with their enable set are touched
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < BEN_WIDTH; b++) begin
        if (ben[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Registered read port, block-RAM style
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/ocp_ram_slave.sv
// OCP slave terminating data/scratch accesses in on-chip RAM; OCP_RAM_ALIGN_CHECK_EN adds misaligned-access ERR.
// Accept WAIT_CYCLES cycles after the command appears, response one cycle after accept, held for one cycle.
// Holds off the master by keeping scmd_accept low during wait states and the response cycle.
module ocp_ram_slave
  import ocp_ram_slave_pkg::*;
#(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic            clk,
  input  logic            nrst,
  ocp_ram_slave_if.slave  bus
);

  localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_t                state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic                  accept;
  logic                  out_of_range;
  logic                  bad_addr;
  logic                  ram_we, ram_re;
  logic [1:0]            resp_q;
  logic                  rd_q;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign out_of_range = |bus.maddr[ADDR_WIDTH-1:ADDR_BITS+2];

`ifdef OCP_RAM_ALIGN_CHECK_EN
  assign bad_addr = (|bus.maddr[1:0]) | out_of_range;
`else
  // Byte offset is ignored: the access goes to the containing word
  logic unused_byte_offset;
  assign unused_byte_offset = ^bus.maddr[1:0];
  assign bad_addr = out_of_range;
`endif

  // The memory is only touched in the accept cycle, and never for rejected accesses
  assign ram_we = accept & (bus.mcmd == CMD_WR) & ~bad_addr;
  assign ram_re = accept & (bus.mcmd == CMD_RD) & ~bad_addr;

  // FSM state and wait counter
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state, counter and combinational accept
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.mcmd != CMD_IDLE) begin
          if (WAIT_CYCLES == 0) begin
            accept    = 1'b1;
            state_nxt = ST_RESP;
          end else begin
            cnt_nxt   = WAIT_LOAD;
            state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          accept    = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Response code captured at accept; outside the response cycle it falls back to NULL
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      resp_q <= RESP_NULL;
      rd_q   <= 1'b0;
    end else begin
      resp_q <= accept ? access_resp(bus.mcmd, bad_addr) : RESP_NULL;
      rd_q   <= ram_re;
    end
  end

  ocp_ram_array #(.ADDR_BITS(ADDR_BITS)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (bus.maddr[ADDR_BITS+1:2]),
    .ben   (bus.mbyte_en),
    .wdata (bus.mdata),
    .rdata (ram_rdata)
  );

  assign bus.scmd_accept = accept;
  assign bus.sresp       = resp_q;
  // Only a successful read exposes RAM data; everything else reads as zero
  assign bus.sdata       = rd_q ? ram_rdata : '0;

endmodule

// File: tb/tb_ocp_ram_slave.sv
// Bench for ocp_ram_slave: three instances with 0, 3 and 5 wait states.
// Expected responses are queued when a command is driven and popped at the response cycle.
// Master holds each command until accept, then returns to IDLE.
module tb_ocp_ram_slave;
  import ocp_ram_slave_pkg::*;

  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nrst  [3];
  logic [31:0] maddr [3];
  logic [2:0]  mcmd  [3];
  logic [31:0] mdata [3];
  logic [3:0]  mben  [3];
  logic        acc   [3];
  logic [31:0] sdat  [3];
  logic [1:0]  srsp  [3];

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

  ocp_ram_slave_if bus0 ();
  ocp_ram_slave_if bus3 ();
  ocp_ram_slave_if bus5 ();

  assign bus0.maddr = maddr[0]; assign bus0.mcmd = mcmd[0];
  assign bus0.mdata = mdata[0]; assign bus0.mbyte_en = mben[0];
  assign bus3.maddr = maddr[1]; assign bus3.mcmd = mcmd[1];
  assign bus3.mdata = mdata[1]; assign bus3.mbyte_en = mben[1];
  assign bus5.maddr = maddr[2]; assign bus5.mcmd = mcmd[2];
  assign bus5.mdata = mdata[2]; assign bus5.mbyte_en = mben[2];

  assign acc[0] = bus0.scmd_accept; assign sdat[0] = bus0.sdata; assign srsp[0] = bus0.sresp;
  assign acc[1] = bus3.scmd_accept; assign sdat[1] = bus3.sdata; assign srsp[1] = bus3.sresp;
  assign acc[2] = bus5.scmd_accept; assign sdat[2] = bus5.sdata; assign srsp[2] = bus5.sresp;

  ocp_ram_slave #(.ADDR_BITS(10), .WAIT_CYCLES(0)) dut0 (.clk(clk), .nrst(nrst[0]), .bus(bus0));
  ocp_ram_slave #(.ADDR_BITS(10), .WAIT_CYCLES(3)) dut3 (.clk(clk), .nrst(nrst[1]), .bus(bus3));
  ocp_ram_slave #(.ADDR_BITS(10), .WAIT_CYCLES(5)) dut5 (.clk(clk), .nrst(nrst[2]), .bus(bus5));

  function automatic int wait_of(input int k);
    case (k)
      0:       return 0;
      1:       return 3;
      default: return 5;
    endcase
  endfunction

  // Drive one command on channel k, check accept timing, the response and that it lasts one cycle
  task automatic issue(input int k, input logic [2:0] cmd, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] ben,
                       input logic [1:0] er, input logic [31:0] ed, input string nm);
    exp_t e;
    int   n;
    bit   got;
    exp_q.push_back({er, ed});
    @(posedge clk); #1;
    mcmd[k] = cmd; maddr[k] = addr; mdata[k] = data; mben[k] = ben;
    n = 0; got = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (acc[k] === 1'b1) got = 1;
      else begin @(posedge clk); #1; end
    end
    checks++;
    if (!got || n != wait_of(k) + 1) begin
      fails++;
      $display("FAIL %s accept_cycle: got %0d (accepted=%0b) expected %0d", nm, n, got, wait_of(k) + 1);
    end
    @(posedge clk); #1;
    mcmd[k] = CMD_IDLE; maddr[k] = $urandom; mdata[k] = $urandom; mben[k] = 4'($urandom);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (srsp[k] !== e.resp) begin
      fails++;
      $display("FAIL %s sresp: got %0d expected %0d", nm, srsp[k], e.resp);
    end
    checks++;
    if (sdat[k] !== e.data) begin
      fails++;
      $display("FAIL %s sdata: got %h expected %h", nm, sdat[k], e.data);
    end
    @(negedge clk);
    checks++;
    if (srsp[k] !== RESP_NULL || sdat[k] !== 32'h0) begin
      fails++;
      $display("FAIL %s resp_pulse: got resp %0d data %h expected %0d / 0", nm, srsp[k], sdat[k], RESP_NULL);
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      nrst[k] = 1'b0; mcmd[k] = CMD_IDLE; maddr[k] = '0; mdata[k] = '0; mben[k] = '0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (srsp[k] !== RESP_NULL || sdat[k] !== 32'h0 || acc[k] !== 1'b0) begin
        fails++;
        $display("FAIL reset_values[%0d]: got resp %0d data %h acc %b expected 0 0 0", k, srsp[k], sdat[k], acc[k]);
      end
    end
    mcmd[0] = CMD_RD; mcmd[1] = CMD_RD;
    #1;
    checks++;
    if (acc[0] !== 1'b1) begin
      fails++;
      $display("FAIL reset_accept_w0: got %b expected 1", acc[0]);
    end
    checks++;
    if (acc[1] !== 1'b0) begin
      fails++;
      $display("FAIL reset_accept_w3: got %b expected 0", acc[1]);
    end
    mcmd[0] = CMD_IDLE; mcmd[1] = CMD_IDLE;
    @(negedge clk);
    for (int k = 0; k < 3; k++) nrst[k] = 1'b1;
  endtask

  task automatic test_write_read();
    issue(0, CMD_WR, 32'h10, 32'hDEADBEEF, 4'hF, RESP_DVA, 32'h0, "wr_0x10");
    issue(0, CMD_RD, 32'h10, 32'h0, 4'h0, RESP_DVA, 32'hDEADBEEF, "rd_0x10");
  endtask

  task automatic test_byte_enable();
    issue(0, CMD_WR, 32'h20, 32'h11223344, 4'hF, RESP_DVA, 32'h0, "preload_0x20");
    issue(0, CMD_WR, 32'h20, 32'hAABBCCDD, 4'b0101, RESP_DVA, 32'h0, "wr_ben0101");
    issue(0, CMD_RD, 32'h20, 32'h0, 4'hF, RESP_DVA, 32'h11BB33DD, "rd_ben0101");
    issue(0, CMD_WR, 32'h20, 32'h55555555, 4'b0000, RESP_DVA, 32'h0, "wr_ben0000");
    issue(0, CMD_RD, 32'h20, 32'h0, 4'h0, RESP_DVA, 32'h11BB33DD, "rd_ben0000");
  endtask

  task automatic test_wait_states();
    issue(1, CMD_WR, 32'h8, 32'h0BADC0DE, 4'hF, RESP_DVA, 32'h0, "w3_wr");
    issue(1, CMD_RD, 32'h8, 32'h0, 4'h0, RESP_DVA, 32'h0BADC0DE, "w3_rd");
    issue(1, 3'd6, 32'h8, 32'h0, 4'h0, RESP_FAIL, 32'h0, "w3_cmd6");
  endtask

  task automatic test_out_of_range();
    issue(0, CMD_WR, 32'h0, 32'h12345678, 4'hF, RESP_DVA, 32'h0, "wr_0x0");
    issue(0, CMD_WR, 32'h00001000, 32'hFFFFFFFF, 4'hF, RESP_ERR, 32'h0, "wr_oor");
    issue(0, CMD_RD, 32'h0, 32'h0, 4'h0, RESP_DVA, 32'h12345678, "rd_0x0_after_oor");
    issue(0, CMD_RD, 32'h80000100, 32'h0, 4'h0, RESP_ERR, 32'h0, "rd_oor");
  endtask

  task automatic test_unsupported();
    issue(0, 3'b101, 32'h10, 32'h0, 4'hF, RESP_FAIL, 32'h0, "cmd5");
    issue(0, 3'b011, 32'h10, 32'h0, 4'hF, RESP_FAIL, 32'h0, "cmd3");
    issue(0, 3'b111, 32'h10, 32'h77777777, 4'hF, RESP_FAIL, 32'h0, "cmd7");
    issue(0, CMD_RD, 32'h10, 32'h0, 4'h0, RESP_DVA, 32'hDEADBEEF, "rd_after_cmd7");
  endtask

  task automatic test_align();
`ifdef OCP_RAM_ALIGN_CHECK_EN
    issue(0, CMD_RD, 32'h22, 32'h0, 4'h0, RESP_ERR, 32'h0, "rd_misaligned");
    issue(0, CMD_WR, 32'h21, 32'h0, 4'hF, RESP_ERR, 32'h0, "wr_misaligned");
    issue(0, CMD_RD, 32'h20, 32'h0, 4'h0, RESP_DVA, 32'h11BB33DD, "rd_after_misaligned");
`else
    issue(0, CMD_RD, 32'h22, 32'h0, 4'h0, RESP_DVA, 32'h11BB33DD, "rd_unaligned");
    issue(0, CMD_WR, 32'h23, 32'hCAFE0000, 4'b1100, RESP_DVA, 32'h0, "wr_unaligned");
    issue(0, CMD_RD, 32'h20, 32'h0, 4'h0, RESP_DVA, 32'hCAFE33DD, "rd_after_unaligned");
`endif
  endtask

  task automatic test_back_to_back();
    logic [31:0] model [8];
    logic [31:0] full, part;
    logic [3:0]  ben;
    for (int i = 0; i < 8; i++) begin
      full = $urandom; part = $urandom; ben = 4'($urandom_range(0, 15));
      for (int b = 0; b < 4; b++) model[i][8*b +: 8] = ben[b] ? part[8*b +: 8] : full[8*b +: 8];
      issue(0, CMD_WR, 32'h100 + 32'(4*i), full, 4'hF, RESP_DVA, 32'h0, "seq_wr_full");
      issue(0, CMD_WR, 32'h100 + 32'(4*i), part, ben, RESP_DVA, 32'h0, "seq_wr_part");
    end
    for (int i = 0; i < 8; i++) begin
      issue(0, CMD_RD, 32'h100 + 32'(4*i), 32'h0, 4'($urandom), RESP_DVA, model[i], "seq_rd");
    end
  endtask

  task automatic test_reset_mid_wait();
    bit quiet;
    issue(2, CMD_WR, 32'h40, 32'hCAFEF00D, 4'hF, RESP_DVA, 32'h0, "w5_wr");
    @(posedge clk); #1;
    mcmd[2] = CMD_RD; maddr[2] = 32'h40;
    @(negedge clk);
    @(negedge clk);
    nrst[2] = 1'b0;
    #1;
    checks++;
    if (dut5.state !== ST_IDLE) begin
      fails++;
      $display("FAIL midwait_state: got %0d expected %0d", dut5.state, ST_IDLE);
    end
    mcmd[2] = CMD_IDLE;
    quiet = 1;
    repeat (2) begin
      @(negedge clk);
      if (srsp[2] !== RESP_NULL || acc[2] !== 1'b0) quiet = 0;
    end
    nrst[2] = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (srsp[2] !== RESP_NULL || acc[2] !== 1'b0) quiet = 0;
    end
    checks++;
    if (!quiet) begin
      fails++;
      $display("FAIL midwait_quiet: got a response or accept after reset, expected none");
    end
    issue(2, CMD_RD, 32'h40, 32'h0, 4'h0, RESP_DVA, 32'hCAFEF00D, "w5_rd_after_reset");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_enable();
    test_wait_states();
    test_out_of_range();
    test_unsupported();
    test_align();
    test_back_to_back();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
